// File: rtl/chan_fifo.sv
// chan_fifo: loopback FIFO that connects to the FX2 comm channel interface.
//   FIFO_CHAN : host writes push bytes and host reads pop them, in order.
//   STAT_CHAN : reads return the occupancy, and any write flushes the FIFO.
//   any other : writes are accepted and discarded, and reads return 0x00.
// Ports:
//   clk_in, reset_in          clock, synchronous active-high reset
//   chanAddr_in[6:0]          currently selected channel
//   h2fData_in/Valid_in       host->FPGA byte stream; h2fReady_out is back-pressure
//   f2hData_out/Valid_out     FPGA->host byte stream; f2hReady_in is the host accept
//   count_out[7:0]            occupancy, zero-extended (for LEDs)
// All outputs are combinational from registered state and the current inputs.
module chan_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [6:0]  FIFO_CHAN  = 7'd0,
  parameter logic [6:0]  STAT_CHAN  = 7'd1
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [6:0] chanAddr_in,
  input  logic [7:0] h2fData_in,
  input  logic       h2fValid_in,
  output logic       h2fReady_out,
  output logic [7:0] f2hData_out,
  output logic       f2hValid_out,
  input  logic       f2hReady_in,
  output logic [7:0] count_out
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic fifo_sel, stat_sel, full, empty, push, pop, flush;

  // Channel decode and transfer qualification
  always_comb begin
    fifo_sel = (chanAddr_in == FIFO_CHAN);
    stat_sel = (chanAddr_in == STAT_CHAN);
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == CW'(0));
    // Full gates push on the current count, so a same-cycle pop does not open a slot
    push     = fifo_sel && h2fValid_in && !full;
    pop      = fifo_sel && f2hReady_in && !empty;
    flush    = stat_sel && h2fValid_in;
  end

  // Pointer and occupancy next-state; flush overrides push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk_in) begin
    if (push && !reset_in) mem_q[wr_ptr_q] <= h2fData_in;
  end

  // Output mux on the selected channel
  always_comb begin
    h2fReady_out = 1'b1;
    f2hValid_out = 1'b1;
    f2hData_out  = 8'h00;
    if (fifo_sel) begin
      h2fReady_out = !full;
      f2hValid_out = !empty;
      f2hData_out  = mem_q[rd_ptr_q];
    end else if (stat_sel) begin
      f2hData_out  = 8'(count_q);
    end
    count_out = 8'(count_q);
  end

endmodule

// File: tb/tb_chan_fifo.sv
// Bench for chan_fifo: directed scenarios plus randomized traffic, checked
// against a queue-based model of the channel behaviour.
module tb_chan_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk;
  logic       rst;
  logic [6:0] chan;
  logic [7:0] h2f_data;
  logic       h2f_valid;
  logic       h2f_ready;
  logic [7:0] f2h_data;
  logic       f2h_valid;
  logic       f2h_ready;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];

  chan_fifo #(.DEPTH_LOG2(4), .FIFO_CHAN(7'd0), .STAT_CHAN(7'd1)) dut (
    .clk_in      (clk),
    .reset_in    (rst),
    .chanAddr_in (chan),
    .h2fData_in  (h2f_data),
    .h2fValid_in (h2f_valid),
    .h2fReady_out(h2f_ready),
    .f2hData_out (f2h_data),
    .f2hValid_out(f2h_valid),
    .f2hReady_in (f2h_ready),
    .count_out   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after the falling edge and let them settle
  task automatic drive(input logic [6:0] ch, input logic hv, input logic [7:0] hd, input logic fr);
    chan      = ch;
    h2f_valid = hv;
    h2f_data  = hd;
    f2h_ready = fr;
    #1;
  endtask

  // Advance one clock and apply the channel rules to the model
  task automatic tick();
    bit         is_fifo, is_stat, do_push, do_pop, do_flush, do_rst;
    logic [7:0] byte_in;
    is_fifo  = (chan == 7'd0);
    is_stat  = (chan == 7'd1);
    do_push  = is_fifo && h2f_valid && (model_q.size() < DEPTH);
    do_pop   = is_fifo && f2h_ready && (model_q.size() > 0);
    do_flush = is_stat && h2f_valid;
    do_rst   = rst;
    byte_in  = h2f_data;
    @(posedge clk);
    if (do_rst || do_flush) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(byte_in);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(7'd0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(7'd0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (h2f_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", h2f_ready); end
    checks++;
    if (f2h_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", f2h_valid); end
    checks++;
    if (count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h expected 00", count); end
    drive(7'd1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (f2h_data !== 8'h00) begin errors++; $display("FAIL reset_stat: got %h expected 00", f2h_data); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(7'd0, 1'b1, vals[i], 1'b0);
      tick();
    end
    drive(7'd1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (f2h_data !== 8'h03) begin errors++; $display("FAIL basic_stat3: got %h expected 03", f2h_data); end
    for (int i = 0; i < 3; i++) begin
      drive(7'd0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (f2h_valid !== 1'b1 || f2h_data !== vals[i]) begin
        errors++; $display("FAIL basic_read%0d: got v=%b d=%h expected v=1 d=%h", i, f2h_valid, f2h_data, vals[i]);
      end
      tick();
    end
    drive(7'd0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (f2h_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b expected 0", f2h_valid); end
    drive(7'd1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (f2h_data !== 8'h00) begin errors++; $display("FAIL basic_stat0: got %h expected 00", f2h_data); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 20; i++) begin
      drive(7'd0, 1'b1, 8'(i), 1'b0);
      checks++;
      if (h2f_ready !== (i < 16)) begin
        errors++; $display("FAIL full_ready%0d: got %b expected %b", i, h2f_ready, (i < 16));
      end
      tick();
    end
    drive(7'd0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== 8'h10) begin errors++; $display("FAIL full_count: got %h expected 10", count); end
    // Pop while full with a write offered: the write must still be refused
    drive(7'd0, 1'b1, 8'hEE, 1'b1);
    checks++;
    if (h2f_ready !== 1'b0 || f2h_data !== 8'h00) begin
      errors++; $display("FAIL full_popwrite: got r=%b d=%h expected r=0 d=00", h2f_ready, f2h_data);
    end
    tick();
    for (int i = 1; i < 16; i++) begin
      drive(7'd0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (f2h_valid !== 1'b1 || f2h_data !== 8'(i)) begin
        errors++; $display("FAIL full_read%0d: got v=%b d=%h expected v=1 d=%h", i, f2h_valid, f2h_data, 8'(i));
      end
      tick();
    end
    drive(7'd0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== 8'h00 || f2h_valid !== 1'b0) begin
      errors++; $display("FAIL full_drained: got c=%h v=%b expected c=00 v=0", count, f2h_valid);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 10; i++) begin
        drive(7'd0, 1'b1, 8'($urandom), 1'b0);
        tick();
      end
      for (int i = 0; i < 10; i++) begin
        drive(7'd0, 1'b0, 8'h00, 1'b1);
        exp_b = model_q[0];
        checks++;
        if (f2h_valid !== 1'b1 || f2h_data !== exp_b) begin
          errors++; $display("FAIL wrap_r%0d_b%0d: got v=%b d=%h expected v=1 d=%h", r, i, f2h_valid, f2h_data, exp_b);
        end
        tick();
      end
      drive(7'd0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (count !== 8'h00) begin errors++; $display("FAIL wrap_count_r%0d: got %h expected 00", r, count); end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      drive(7'd0, 1'b1, 8'(8'h40 + i), 1'b0);
      tick();
    end
    drive(7'd1, 1'b1, 8'hA5, 1'b0);
    tick();
    drive(7'd0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== 8'h00 || f2h_valid !== 1'b0) begin
      errors++; $display("FAIL flush_state: got c=%h v=%b expected c=00 v=0", count, f2h_valid);
    end
    drive(7'd0, 1'b1, 8'h77, 1'b0);
    tick();
    drive(7'd0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (f2h_valid !== 1'b1 || f2h_data !== 8'h77) begin
      errors++; $display("FAIL flush_after: got v=%b d=%h expected v=1 d=77", f2h_valid, f2h_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_and_other_chan();
    for (int i = 0; i < 7; i++) begin
      drive(7'd0, 1'b1, 8'(8'h60 + i), 1'b0);
      tick();
    end
    // Reset coincides with a push; reset must win
    rst = 1'b1;
    drive(7'd0, 1'b1, 8'h99, 1'b1);
    tick();
    rst = 1'b0;
    drive(7'd0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== 8'h00 || f2h_valid !== 1'b0) begin
      errors++; $display("FAIL midreset: got c=%h v=%b expected c=00 v=0", count, f2h_valid);
    end
    drive(7'd0, 1'b1, 8'h5A, 1'b0);
    tick();
    drive(7'd5, 1'b1, 8'hC3, 1'b1);
    checks++;
    if (h2f_ready !== 1'b1 || f2h_valid !== 1'b1 || f2h_data !== 8'h00) begin
      errors++; $display("FAIL chan5_out: got r=%b v=%b d=%h expected r=1 v=1 d=00", h2f_ready, f2h_valid, f2h_data);
    end
    tick();
    drive(7'd5, 1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== 8'h01) begin errors++; $display("FAIL chan5_count: got %h expected 01", count); end
    drive(7'd0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (f2h_data !== 8'h5A) begin errors++; $display("FAIL chan5_data: got %h expected 5A", f2h_data); end
    tick();
  endtask

  task automatic test_random();
    int         r;
    logic [6:0] ch;
    logic       hv;
    logic       exp_rdy, exp_vld;
    logic [7:0] exp_dat;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 39));
      if (r < 32)      ch = 7'd0;
      else if (r < 33) ch = 7'd1;
      else if (r < 36) ch = 7'd5;
      else             ch = 7'd1;
      hv = (ch == 7'd1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      drive(ch, hv, 8'($urandom), 1'($urandom));
      exp_rdy = 1'b1;
      exp_vld = 1'b1;
      exp_dat = 8'h00;
      if (ch == 7'd0) begin
        exp_rdy = (model_q.size() < DEPTH);
        exp_vld = (model_q.size() > 0);
        if (exp_vld) exp_dat = model_q[0];
      end else if (ch == 7'd1) begin
        exp_dat = 8'(model_q.size());
      end
      checks++;
      if (count !== 8'(model_q.size()) || h2f_ready !== exp_rdy || f2h_valid !== exp_vld ||
          (exp_vld && f2h_data !== exp_dat)) begin
        errors++;
        $display("FAIL rand%0d ch%0d: got c=%h r=%b v=%b d=%h expected c=%h r=%b v=%b d=%h",
                 n, ch, count, h2f_ready, f2h_valid, f2h_data, 8'(model_q.size()), exp_rdy, exp_vld, exp_dat);
      end
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    chan      = 7'd0;
    h2f_data  = 8'h00;
    h2f_valid = 1'b0;
    f2h_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid_and_other_chan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
